// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and default widths for the register-file write arbiter.
//   DefaultDataW / DefaultAddrW : default write-data and register-index widths
//   arb_state_e                 : starvation FSM states
//   src_e                       : which writer owns the write port this cycle
package rf_arb_pkg;

   localparam int unsigned DefaultDataW = 32;
   localparam int unsigned DefaultAddrW = 5;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StStall
   } arb_state_e;

   typedef enum logic [1:0] {
      SrcNone,
      SrcWb,
      SrcMdu,
      SrcDbg
   } src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: the writer-side and register-file-side signals of the arbiter.
//   wb_*       : pipeline writeback request (no back-pressure)
//   mdu_*      : mul/div result push (valid/ready)
//   dbg_*      : debug loader request (valid/ready, held until ready)
//   stall_req  : one-cycle bubble request to the pipeline
//   rf_*       : register file write port
// Modports: master = the writers / register file side, slave = the arbiter.
interface rf_write_arbiter_if
   import rf_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DefaultDataW,
   parameter int unsigned ADDR_W = DefaultAddrW
);

   logic              wb_reg_write;
   logic [ADDR_W-1:0] wb_write_reg;
   logic [DATA_W-1:0] wb_write_data;

   logic              mdu_valid;
   logic              mdu_ready;
   logic [ADDR_W-1:0] mdu_write_reg;
   logic [DATA_W-1:0] mdu_write_data;

   logic              dbg_valid;
   logic              dbg_ready;
   logic [ADDR_W-1:0] dbg_write_reg;
   logic [DATA_W-1:0] dbg_write_data;

   logic              stall_req;

   logic              rf_reg_write;
   logic [ADDR_W-1:0] rf_write_reg;
   logic [DATA_W-1:0] rf_write_data;

   modport master (
      output wb_reg_write, wb_write_reg, wb_write_data,
      output mdu_valid, mdu_write_reg, mdu_write_data,
      input  mdu_ready,
      output dbg_valid, dbg_write_reg, dbg_write_data,
      input  dbg_ready,
      input  stall_req,
      input  rf_reg_write, rf_write_reg, rf_write_data
   );

   modport slave (
      input  wb_reg_write, wb_write_reg, wb_write_data,
      input  mdu_valid, mdu_write_reg, mdu_write_data,
      output mdu_ready,
      input  dbg_valid, dbg_write_reg, dbg_write_data,
      output dbg_ready,
      output stall_req,
      output rf_reg_write, rf_write_reg, rf_write_data
   );

endinterface

// File: rtl/rf_write_fifo.sv
// rf_write_fifo: synchronous FIFO queueing MDU write results.
//   clk, reset : clock, synchronous active-high reset (empties the queue)
//   push_i     : enqueue wdata_i (ignored while full)
//   pop_i      : dequeue head (ignored while empty)
//   rdata_o    : current head entry
//   full_o, empty_o, count_o : occupancy
// Depth must be a power of two so the pointers wrap by plain overflow.
module rf_write_fifo #(
   parameter int unsigned Width = 37,
   parameter int unsigned Depth = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [Width-1:0]           wdata_i,
   output logic [Width-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   // Full blocks the push even if a pop happens in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
         else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between pipeline writeback (WB),
// the mul/div unit (MDU, queued) and the debug loader (DBG).
//   clk, reset : clock, synchronous active-high reset
//   bus        : rf_write_arbiter_if slave port (writer requests, rf write port, stall_req)
// WB always wins; leftover slots alternate between the MDU queue head and DBG. A secondary
// writer denied STARVE_LIMIT cycles in a row triggers a one-cycle stall_req bubble.
// DATA_W/ADDR_W must match the parameters of the connected interface.
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned DATA_W       = DefaultDataW,
   parameter int unsigned ADDR_W       = DefaultAddrW,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               reset,
   rf_write_arbiter_if.slave bus
);

   localparam int unsigned EntryW = ADDR_W + DATA_W;
   localparam int unsigned FCntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SCntW  = $clog2(STARVE_LIMIT + 1);

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EntryW-1:0] fifo_head;
   logic [FCntW-1:0]  fifo_count;
   logic              fifo_count_unused;
   logic [ADDR_W-1:0] mdu_head_reg;
   logic [DATA_W-1:0] mdu_head_data;

   src_e              grant;
   logic              mdu_pending, dbg_pending, sec_pending, sec_grant, denied;
   logic              rr_q, rr_d;
   arb_state_e        state_q, state_d;
   logic [SCntW-1:0]  cnt_q, cnt_d;
   logic              stall_req_q;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   // MDU queue: pushed entries are only visible at the head from the next cycle.
   assign bus.mdu_ready = !fifo_full && !reset;
   assign fifo_push     = bus.mdu_valid && bus.mdu_ready;
   assign fifo_pop      = (grant == SrcMdu);
   assign {mdu_head_reg, mdu_head_data} = fifo_head;
   assign fifo_count_unused = ^fifo_count;

   rf_write_fifo #(
      .Width (EntryW),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({bus.mdu_write_reg, bus.mdu_write_data}),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign mdu_pending = !fifo_empty;
   assign dbg_pending = bus.dbg_valid;
   assign sec_pending = mdu_pending || dbg_pending;
   assign sec_grant   = (grant == SrcMdu) || (grant == SrcDbg);
   assign denied      = sec_pending && !sec_grant;

   always_comb begin
      grant = SrcNone;
      if (!reset) begin
         if (bus.wb_reg_write)               grant = SrcWb;
         else if (mdu_pending && dbg_pending) grant = rr_q ? SrcDbg : SrcMdu;
         else if (mdu_pending)               grant = SrcMdu;
         else if (dbg_pending)               grant = SrcDbg;
      end
   end

   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      unique case (grant)
         SrcWb: begin
            sel_reg  = bus.wb_write_reg;
            sel_data = bus.wb_write_data;
         end
         SrcMdu: begin
            sel_reg  = mdu_head_reg;
            sel_data = mdu_head_data;
         end
         SrcDbg: begin
            sel_reg  = bus.dbg_write_reg;
            sel_data = bus.dbg_write_data;
         end
         default: ;
      endcase
   end

   // Writes to register 0 still consume the slot but never reach the register file.
   assign bus.rf_reg_write  = (grant != SrcNone) && (sel_reg != '0);
   assign bus.rf_write_reg  = sel_reg;
   assign bus.rf_write_data = sel_data;
   assign bus.dbg_ready     = (grant == SrcDbg);
   assign bus.stall_req     = stall_req_q;

   always_comb begin
      rr_d = rr_q;
      if (grant == SrcMdu)      rr_d = 1'b1;
      else if (grant == SrcDbg) rr_d = 1'b0;
   end

   // Starvation tracking: WAIT means a secondary was denied last cycle and cnt holds the
   // run length of consecutive denials.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StWait: begin
            if (denied) begin
               if (cnt_q == SCntW'(STARVE_LIMIT - 1)) begin
                  state_d = StStall;
                  cnt_d   = '0;
               end else begin
                  state_d = StWait;
                  cnt_d   = cnt_q + SCntW'(1);
               end
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StStall: begin
            // The bubble cycle never counts, even if WB ignored the request.
            cnt_d   = '0;
            state_d = sec_pending ? StWait : StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q        <= 1'b0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         stall_req_q <= 1'b0;
      end else begin
         rr_q        <= rr_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_req_q <= (state_d == StStall);
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.
// Inputs change 1 time unit after each posedge; outputs are checked 1 unit later.
module tb_rf_write_arbiter;
   import rf_arb_pkg::*;

   logic clk;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   rf_write_arbiter #(
      .DATA_W       (32),
      .ADDR_W       (5),
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.wb_reg_write   = 1'b0;
      bus.wb_write_reg   = '0;
      bus.wb_write_data  = '0;
      bus.mdu_valid      = 1'b0;
      bus.mdu_write_reg  = '0;
      bus.mdu_write_data = '0;
      bus.dbg_valid      = 1'b0;
      bus.dbg_write_reg  = '0;
      bus.dbg_write_data = '0;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
      bus.wb_reg_write  = en;
      bus.wb_write_reg  = r;
      bus.wb_write_data = d;
   endtask

   task automatic set_mdu(input logic en, input logic [4:0] r, input logic [31:0] d);
      bus.mdu_valid      = en;
      bus.mdu_write_reg  = r;
      bus.mdu_write_data = d;
   endtask

   task automatic set_dbg(input logic en, input logic [4:0] r, input logic [31:0] d);
      bus.dbg_valid      = en;
      bus.dbg_write_reg  = r;
      bus.dbg_write_data = d;
   endtask

   initial begin
      // Reset with every writer requesting: nothing may leak out.
      reset = 1'b1;
      drive_idle();
      set_wb(1'b1, 5'd3, 32'h5);
      set_dbg(1'b1, 5'd4, 32'h6);
      set_mdu(1'b1, 5'd7, 32'h7);
      #1;
      chk("rst_rf_we", bus.rf_reg_write, 1'b0);
      chk("rst_mdu_rdy", bus.mdu_ready, 1'b0);
      chk("rst_dbg_rdy", bus.dbg_ready, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      drive_idle();
      #1;
      chk("idle_rf_we", bus.rf_reg_write, 1'b0);
      chk("idle_rf_reg", bus.rf_write_reg, 5'd0);
      chk("idle_rf_data", bus.rf_write_data, 32'h0);
      chk("idle_mdu_rdy", bus.mdu_ready, 1'b1);
      chk("idle_stall", bus.stall_req, 1'b0);
      chk("idle_state", dut.state_q, StIdle);

      // WB only: same-cycle write.
      tick();
      set_wb(1'b1, 5'd17, 32'h00AB_CDEF);
      #1;
      chk("wb_we", bus.rf_reg_write, 1'b1);
      chk("wb_reg", bus.rf_write_reg, 5'd17);
      chk("wb_data", bus.rf_write_data, 32'h00AB_CDEF);

      // MDU pushes on consecutive cycles; each write appears one cycle later.
      tick();
      set_wb(1'b0, 5'd0, 32'h0);
      set_mdu(1'b1, 5'd8, 32'h11);
      #1;
      chk("mdu_push1_rdy", bus.mdu_ready, 1'b1);
      chk("mdu_no_bypass", bus.rf_reg_write, 1'b0);
      tick();
      set_mdu(1'b1, 5'd9, 32'h22);
      #1;
      chk("mdu_w1_we", bus.rf_reg_write, 1'b1);
      chk("mdu_w1_reg", bus.rf_write_reg, 5'd8);
      chk("mdu_w1_data", bus.rf_write_data, 32'h11);
      tick();
      set_mdu(1'b0, 5'd0, 32'h0);
      #1;
      chk("mdu_w2_reg", bus.rf_write_reg, 5'd9);
      chk("mdu_w2_data", bus.rf_write_data, 32'h22);
      tick();
      #1;
      chk("mdu_drained", bus.rf_reg_write, 1'b0);

      // WB held high so two MDU entries stay queued; the third push sees a full FIFO.
      set_wb(1'b1, 5'd1, 32'h1);
      set_mdu(1'b1, 5'd12, 32'h44);
      tick();
      set_mdu(1'b1, 5'd13, 32'h55);
      #1;
      chk("fill2_rdy", bus.mdu_ready, 1'b1);
      chk("fill2_wb_wins", bus.rf_write_reg, 5'd1);
      tick();
      set_mdu(1'b1, 5'd14, 32'h66);
      #1;
      chk("full_rdy", bus.mdu_ready, 1'b0);
      chk("full_count", dut.fifo_count, 2'd2);
      tick();
      set_wb(1'b0, 5'd0, 32'h0);
      set_mdu(1'b0, 5'd0, 32'h0);
      #1;
      chk("q_head1_reg", bus.rf_write_reg, 5'd12);
      chk("q_head1_data", bus.rf_write_data, 32'h44);
      tick();
      #1;
      chk("q_head2_reg", bus.rf_write_reg, 5'd13);
      chk("q_head2_data", bus.rf_write_data, 32'h55);
      tick();

      // DBG write to register 0: handshake completes, register file untouched.
      set_dbg(1'b1, 5'd0, 32'h99);
      #1;
      chk("dbg_r0_rdy", bus.dbg_ready, 1'b1);
      chk("dbg_r0_we", bus.rf_reg_write, 1'b0);
      tick();
      set_dbg(1'b0, 5'd0, 32'h0);
      #1;
      chk("rr_after_dbg", dut.rr_q, 1'b0);

      // MDU and DBG both pending with rr=0: MDU first, then DBG.
      set_mdu(1'b1, 5'd11, 32'h66);
      tick();
      set_mdu(1'b0, 5'd0, 32'h0);
      set_dbg(1'b1, 5'd10, 32'h33);
      #1;
      chk("rr_mdu_reg", bus.rf_write_reg, 5'd11);
      chk("rr_mdu_data", bus.rf_write_data, 32'h66);
      chk("rr_mdu_dbg_rdy", bus.dbg_ready, 1'b0);
      tick();
      #1;
      chk("rr_dbg_rdy", bus.dbg_ready, 1'b1);
      chk("rr_dbg_reg", bus.rf_write_reg, 5'd10);
      chk("rr_dbg_data", bus.rf_write_data, 32'h33);
      tick();
      set_dbg(1'b0, 5'd0, 32'h0);
      #1;
      chk("rr_back_to_0", dut.rr_q, 1'b0);
      chk("rr_idle_we", bus.rf_reg_write, 1'b0);

      // Starvation: WB every cycle while DBG waits; bubble request in cycle 5.
      set_wb(1'b1, 5'd2, 32'hAA);
      set_dbg(1'b1, 5'd10, 32'h77);
      #1;
      chk("starve_c1_stall", bus.stall_req, 1'b0);
      chk("starve_c1_rdy", bus.dbg_ready, 1'b0);
      tick();
      chk("starve_c2_stall", bus.stall_req, 1'b0);
      chk("starve_c2_cnt", dut.cnt_q, 3'd1);
      tick();
      chk("starve_c3_stall", bus.stall_req, 1'b0);
      tick();
      chk("starve_c4_stall", bus.stall_req, 1'b0);
      chk("starve_c4_cnt", dut.cnt_q, 3'd3);
      tick();
      chk("starve_c5_stall", bus.stall_req, 1'b1);
      chk("starve_c5_state", dut.state_q, StStall);
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      chk("bubble_dbg_rdy", bus.dbg_ready, 1'b1);
      chk("bubble_reg", bus.rf_write_reg, 5'd10);
      chk("bubble_data", bus.rf_write_data, 32'h77);
      tick();
      set_dbg(1'b0, 5'd0, 32'h0);
      #1;
      chk("starve_c6_stall", bus.stall_req, 1'b0);
      chk("starve_c6_cnt", dut.cnt_q, 3'd0);

      // Reset with two MDU entries queued discards them.
      set_wb(1'b1, 5'd1, 32'h1);
      set_mdu(1'b1, 5'd20, 32'hDEAD);
      tick();
      set_mdu(1'b1, 5'd21, 32'hBEEF);
      tick();
      set_mdu(1'b0, 5'd0, 32'h0);
      #1;
      chk("pre_rst_count", dut.fifo_count, 2'd2);
      reset = 1'b1;
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      chk("midrst_we", bus.rf_reg_write, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_count", dut.fifo_count, 2'd0);
      chk("post_rst_we", bus.rf_reg_write, 1'b0);
      chk("post_rst_reg", bus.rf_write_reg, 5'd0);
      chk("post_rst_rdy", bus.mdu_ready, 1'b1);
      tick();
      #1;
      chk("post_rst_we2", bus.rf_reg_write, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
